// File: rtl/systolic_result_drain.sv
// ---------------------------------------------------------------------------
// systolic_result_drain
//
// Collects the result stream of a systolic array into a small row-major
// result buffer. A drain begins with start_i. The block then pulses flush_o
// for one cycle so the array pushes its results out. It accepts
// array_width_p*array_height_p words over the valid_i/yumi_o handshake and
// finishes in DONE, or in ERR if the array goes quiet for too long. A
// registered read port lets a host fetch the captured matrix at any time.
//
// Ports
//   clk_i      clock, all state changes on the rising edge
//   reset_i    asynchronous, active-low reset
//   start_i    one-cycle drain request (honoured in IDLE, DONE, ERR)
//   flush_o    one-cycle flush request to the array
//   valid_i    array presents a result word on data_i
//   data_i     result word
//   yumi_o     word consumed this cycle (combinational from valid_i)
//   busy_o     drain in progress (FLUSH or DRAIN)
//   done_o     all words captured, held until the next start_i
//   error_o    drain timed out, held until the next start_i
//   count_o    words captured in the current drain (saturates at N)
//   rd_addr_i  buffer read index, r*array_width_p + c
//   rd_data_o  buffer word at last cycle's rd_addr_i, 0 when out of range
// ---------------------------------------------------------------------------
module systolic_result_drain #(
  parameter int width_p        = 8,
  parameter int array_width_p  = 2,
  parameter int array_height_p = 2,
  parameter int timeout_p      = 16,
  localparam int N             = array_width_p * array_height_p,
  localparam int CNT_W         = $clog2(N + 1),
  localparam int ADDR_W        = (N > 1) ? $clog2(N) : 1,
  localparam int IDLE_W        = (timeout_p > 2) ? $clog2(timeout_p) : 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               start_i,
  output logic               flush_o,
  input  logic               valid_i,
  input  logic [width_p-1:0] data_i,
  output logic               yumi_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               error_o,
  output logic [CNT_W-1:0]   count_o,
  input  logic [ADDR_W-1:0]  rd_addr_i,
  output logic [width_p-1:0] rd_data_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_DRAIN,
    S_DONE,
    S_ERR
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [IDLE_W-1:0]  idle_q, idle_d;
  logic [width_p-1:0] rd_data_q, rd_data_d;
  logic [width_p-1:0] mem_q [N];

  logic accept;
  logic in_drain;

  // The array may hand back word 0 during the flush cycle itself, so both
  // FLUSH and DRAIN accept beats.
  assign in_drain = (state_q == S_FLUSH) || (state_q == S_DRAIN);
  assign accept   = valid_i && in_drain;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idle_d  = idle_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start_i) begin
          state_d = S_FLUSH;
          count_d = '0;
          idle_d  = '0;
        end
      end

      S_FLUSH, S_DRAIN: begin
        if (accept) begin
          // A beat always resets the quiet-time counter, even on the cycle
          // the counter would otherwise have expired.
          idle_d = '0;
          if (count_q != CNT_W'(N)) begin
            count_d = count_q + 1'b1;
          end
          if (count_q == CNT_W'(N - 1)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_DRAIN;
          end
        end else if (state_q == S_FLUSH) begin
          // Quiet time is only measured once the flush request has gone out.
          state_d = S_DRAIN;
        end else if (idle_q == IDLE_W'(timeout_p - 1)) begin
          state_d = S_ERR;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Read port mux; addresses at or beyond N read as zero
  // -------------------------------------------------------------------------
  always_comb begin
    rd_data_d = '0;
    for (int i = 0; i < N; i++) begin
      if (rd_addr_i == ADDR_W'(i)) begin
        rd_data_d = mem_q[i];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Control and read-data registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      idle_q    <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      idle_q    <= idle_d;
      rd_data_q <= rd_data_d;
    end
  end

  // -------------------------------------------------------------------------
  // Result buffer: no reset. The read above samples mem_q before this edge's
  // write lands, so a same-cycle read of the written slot returns the old word.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < N; i++) begin
      if (accept && (count_q == CNT_W'(i))) begin
        mem_q[i] <= data_i;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign flush_o   = (state_q == S_FLUSH);
  assign yumi_o    = accept;
  assign busy_o    = in_drain;
  assign done_o    = (state_q == S_DONE);
  assign error_o   = (state_q == S_ERR);
  assign count_o   = count_q;
  assign rd_data_o = rd_data_q;

endmodule

// File: tb/tb_systolic_result_drain.sv
module tb_systolic_result_drain;
  localparam int W  = 8;
  localparam int AW = 2;
  localparam int AH = 2;
  localparam int TO = 4;
  localparam int N  = AW * AH;

  logic         clk = 1'b0;
  logic         reset_i = 1'b1;
  logic         start_i = 1'b0;
  logic         valid_i = 1'b0;
  logic [W-1:0] data_i = '0;
  logic [1:0]   rd_addr_i = '0;
  logic         flush_o, yumi_o, busy_o, done_o, error_o;
  logic [2:0]   count_o;
  logic [W-1:0] rd_data_o;

  systolic_result_drain #(
    .width_p(W), .array_width_p(AW), .array_height_p(AH), .timeout_p(TO)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .flush_o(flush_o),
    .valid_i(valid_i), .data_i(data_i), .yumi_o(yumi_o), .busy_o(busy_o),
    .done_o(done_o), .error_o(error_o), .count_o(count_o),
    .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_bad    = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 flush, 2 drain, 3 done, 4 error.
  int           ph = 0;
  int           mcnt = 0;
  int           midle = 0;
  logic [W-1:0] mbuf [N];
  bit           mknown [N];
  logic [W-1:0] rd_exp = '0;
  bit           rd_known = 1'b0;

  initial for (int i = 0; i < N; i++) mknown[i] = 1'b0;

  always @(negedge clk) begin
    bit beat;
    if (!reset_i) begin
      ph = 0; mcnt = 0; midle = 0; rd_exp = '0; rd_known = 1'b1;
    end
    beat = reset_i && valid_i && (ph == 1 || ph == 2);
    check("flush_o", int'(flush_o), int'(ph == 1));
    check("yumi_o",  int'(yumi_o),  int'(beat));
    check("busy_o",  int'(busy_o),  int'(ph == 1 || ph == 2));
    check("done_o",  int'(done_o),  int'(ph == 3));
    check("error_o", int'(error_o), int'(ph == 4));
    check("count_o", int'(count_o), mcnt);
    if (rd_known) check("rd_data_o", int'(rd_data_o), int'(rd_exp));
    if (reset_i) begin
      if (int'(rd_addr_i) < N) begin
        rd_exp   = mbuf[rd_addr_i];
        rd_known = mknown[rd_addr_i];
      end else begin
        rd_exp   = '0;
        rd_known = 1'b1;
      end
      if (ph == 0 || ph == 3 || ph == 4) begin
        if (start_i) begin ph = 1; mcnt = 0; midle = 0; end
      end else if (beat) begin
        mbuf[mcnt] = data_i; mknown[mcnt] = 1'b1;
        mcnt++; midle = 0;
        ph = (mcnt == N) ? 3 : 2;
      end else if (ph == 1) begin
        ph = 2;
      end else if (midle == TO - 1) begin
        ph = 4;
      end else begin
        midle++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic send4(input logic [W-1:0] a, b, c, d);
    logic [W-1:0] v [4];
    v[0] = a; v[1] = b; v[2] = c; v[3] = d;
    for (int i = 0; i < 4; i++) begin
      valid_i = 1'b1; data_i = v[i];
      tick();
    end
    valid_i = 1'b0;
  endtask

  task automatic read_check(input string name, input int addr, input int exp);
    rd_addr_i = addr[1:0];
    tick();
    check(name, int'(rd_data_o), exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int fl;
    int gap_vals [4];
    int gi;
    #1 reset_i = 1'b0;
    tick();
    check("reset_count", int'(count_o), 0);
    check("reset_busy", int'(busy_o), 0);
    check("reset_rd", int'(rd_data_o), 0);
    tick();
    reset_i = 1'b1;

    // valid in IDLE is not consumed
    valid_i = 1'b1; data_i = 8'hAA;
    tick(); tick();
    valid_i = 1'b0;
    check("idle_aa_count", int'(count_o), 0);

    // back-to-back drain starting in the flush cycle
    do_start();
    check("t1_flush", int'(flush_o), 1);
    send4(8'd7, 8'd10, 8'd15, 8'd22);
    check("t1_done", int'(done_o), 1);
    check("t1_count", int'(count_o), 4);
    read_check("t1_rd0", 0, 7);
    read_check("t1_rd1", 1, 10);
    read_check("t1_rd2", 2, 15);
    read_check("t1_rd3", 3, 22);

    // valid in DONE is not consumed
    valid_i = 1'b1; data_i = 8'hAA;
    tick(); tick();
    valid_i = 1'b0;
    check("done_aa_count", int'(count_o), 4);
    read_check("done_aa_rd3", 3, 22);

    // gapped beats on cycles 2, 5, 6, 9 after start
    gap_vals[0] = 7; gap_vals[1] = 10; gap_vals[2] = 15; gap_vals[3] = 22;
    gi = 0;
    do_start();
    for (int k = 1; k <= 11; k++) begin
      valid_i = (k == 2 || k == 5 || k == 6 || k == 9);
      data_i  = valid_i ? gap_vals[gi][W-1:0] : 8'h55;
      if (valid_i) gi++;
      tick();
    end
    valid_i = 1'b0;
    check("gap_done", int'(done_o), 1);
    check("gap_err", int'(error_o), 0);
    read_check("gap_rd0", 0, 7);
    read_check("gap_rd3", 3, 22);

    // timeout after two beats
    do_start();
    valid_i = 1'b1; data_i = 8'd33; tick();
    data_i = 8'd44; tick();
    valid_i = 1'b0;
    n = 0;
    while (!error_o && n < 20) begin tick(); n++; end
    check("to_latency", n, 4);
    check("to_count", int'(count_o), 2);
    check("to_done", int'(done_o), 0);
    do_start();
    check("to_restart_err", int'(error_o), 0);
    check("to_restart_flush", int'(flush_o), 1);
    send4(8'd5, 8'd6, 8'd7, 8'd8);
    check("to_restart_done", int'(done_o), 1);

    // start_i during drain is ignored
    do_start();
    fl = int'(flush_o);
    for (int i = 0; i < 4; i++) begin
      valid_i = 1'b1; data_i = W'(60 + i);
      start_i = (i == 1 || i == 2);
      tick();
      fl += int'(flush_o);
    end
    valid_i = 1'b0; start_i = 1'b0;
    check("sd_flushes", fl, 1);
    check("sd_count", int'(count_o), 4);
    check("sd_done", int'(done_o), 1);

    // reset mid-drain
    do_start();
    valid_i = 1'b1; data_i = 8'd50; tick();
    data_i = 8'd51; tick();
    data_i = 8'd52;
    #2 reset_i = 1'b0;
    #1;
    check("rst_busy", int'(busy_o), 0);
    check("rst_count", int'(count_o), 0);
    check("rst_yumi", int'(yumi_o), 0);
    check("rst_flush", int'(flush_o), 0);
    check("rst_rd", int'(rd_data_o), 0);
    valid_i = 1'b0;
    tick();
    reset_i = 1'b1;
    do_start();
    send4(8'd1, 8'd2, 8'd3, 8'd4);
    check("rst_done", int'(done_o), 1);
    read_check("rst_rd0", 0, 1);
    read_check("rst_rd1", 1, 2);
    read_check("rst_rd2", 2, 3);
    read_check("rst_rd3", 3, 4);

    // randomized traffic against the model
    for (int blk = 0; blk < 6; blk++) begin
      int thr;
      thr = (blk % 2 == 0) ? 75 : 20;
      for (int c = 0; c < 100; c++) begin
        start_i   = ($urandom_range(0, 11) == 0);
        valid_i   = ($urandom_range(0, 99) < thr);
        data_i    = W'($urandom);
        rd_addr_i = 2'($urandom_range(0, 3));
        tick();
      end
    end
    start_i = 1'b0; valid_i = 1'b0;
    tick(); tick();

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end
endmodule
